sd_spi_slave: RTL

SD_SPI_SLAVE -- requirements
Module: sd_spi_slave

---
 rtl/sd_spi_slave.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sd_spi_slave.sv
// SPI mode-0 slave on clock50: 2-flop synchronized pins, bytes MSB first, reacts within 3 cycles of a pin edge.
// One-byte rx holding register (sticky overrun) and a one-deep tx hold register that is consumed at byte boundaries.
module sd_spi_slave #(
  parameter int MIN_HALF = 3
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       SPI_CS,
  input  logic       SPI_SCLK,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full,
  output logic       selected
);

  // After reset, CS must be seen high on real (flushed) synchronizer data before a falling edge counts.
  localparam int         WARM     = (MIN_HALF > 2) ? MIN_HALF : 2;
  localparam logic [7:0] WARM_CNT = 8'(WARM);

  logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic       cs_prev_q, sclk_prev_q;
  logic [7:0] warm_q, warm_d;
  logic       armed_q, armed_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_full_q, tx_full_d;

  logic cs_s, sclk_s, mosi_s;
  logic cs_rise, cs_fall, active, sclk_rise, sclk_fall, byte_done, boundary;

  assign cs_s   = cs_sync_q[1];
  assign sclk_s = sclk_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  assign cs_rise   = ~cs_prev_q & cs_s;
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign active    = armed_q & ~cs_prev_q & ~cs_s;
  assign sclk_rise = active & ~sclk_prev_q & sclk_s;
  assign sclk_fall = active & sclk_prev_q & ~sclk_s;
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
  assign boundary  = cs_fall | byte_done;

  always_comb begin
    warm_d       = (warm_q == WARM_CNT) ? warm_q : warm_q + 8'd1;
    armed_d      = armed_q | ((warm_q == WARM_CNT) & cs_s);
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ack;
    rx_overrun_d = rx_overrun_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    tx_full_d    = tx_full_q;

    if (cs_rise) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = 8'hFF;
    end else if (cs_fall) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
    end else if (sclk_rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b1};
    end

    // A completing byte beats a same-cycle ack and is not an overrun in that case.
    if (byte_done) begin
      rx_data_d    = {rx_shift_q[6:0], mosi_s};
      rx_valid_d   = 1'b1;
      rx_overrun_d = rx_overrun_q | (rx_valid_q & ~rx_ack);
    end

    if (boundary) begin
      tx_shift_d = tx_full_q ? hold_q : 8'hFF;
      tx_full_d  = 1'b0;
    end

    // Applied after the boundary so a coincident load lands in hold for the following byte.
    if (tx_load) begin
      hold_d    = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      cs_sync_q    <= 2'b11;
      sclk_sync_q  <= 2'b00;
      mosi_sync_q  <= 2'b11;
      cs_prev_q    <= 1'b1;
      sclk_prev_q  <= 1'b0;
      warm_q       <= 8'd0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_shift_q   <= 8'hFF;
      hold_q       <= 8'h00;
      tx_full_q    <= 1'b0;
    end else begin
      cs_sync_q    <= {cs_sync_q[0], SPI_CS};
      sclk_sync_q  <= {sclk_sync_q[0], SPI_SCLK};
      mosi_sync_q  <= {mosi_sync_q[0], SPI_MOSI};
      cs_prev_q    <= cs_s;
      sclk_prev_q  <= sclk_s;
      warm_q       <= warm_d;
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      tx_full_q    <= tx_full_d;
    end
  end

  assign SPI_MISO   = cs_s | tx_shift_q[7];
  assign selected   = ~cs_s;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign tx_full    = tx_full_q;

endmodule
